ram_access_controller: RTL and testbench
========================================

Name: ram_access_controller

Overview:
- Initiator-side master for the 512x32 synchronous `ram`.
- Accepts single or burst (1–8 word) read/write requests from the CPU control path over a valid/ready handshake.
- Drives the RAM's D/address/read/write strobes with registered outputs.
- Returns read data as a per-beat valid stream, with a done pulse at the end of each transaction.
- Sits between the control unit/MDR-MAR logic and the `ram` instance.

Parameters:
- ADDR_W, 9, RAM address width (depth 2^ADDR_W = 512).
- DATA_W, 32, data word width.
- LEN_W, 3, burst length field width; burst words = req_len+1.
- READ_LATENCY, 1, edges from RAM sampling a read strobe until ram_Q is valid (RAM has a registered output).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- clear  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  burst start address.
- req_len  in  LEN_W  burst length minus 1.
- wdata  in  DATA_W  write beat data.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  controller consumes wdata this edge.
- rdata  out  DATA_W  read beat data.
- rvalid  out  1  one-cycle pulse per read beat.
- done  out  1  one-cycle pulse; transaction complete.
- busy  out  1  high whenever state != IDLE.
- ram_D  out  DATA_W  to ram.D.
- ram_address  out  ADDR_W  to ram.address.
- ram_read  out  1  to ram.read.
- ram_write  out  1  to ram.write.
- ram_Q  in  DATA_W  from ram.Q.

Behaviour:
- Clock and reset: one clock, `clock`; reset `clear` is synchronous and active-high.
- Reset values (edge with clear=1):
  - state=IDLE.
  - ram_read=0, ram_write=0, ram_address=0, ram_D=0.
  - rdata=0, rvalid=0, done=0, busy=0, wdata_ready=0.
  - Read-pending pipeline flushed.
  - req_ready is forced 0 while clear=1.
- States: IDLE, RD_ISSUE, RD_DRAIN, WR, FINISH.
- IDLE:
  - req_ready=1.
  - On req_valid at edge A: latch addr, len, write; beat counter=0.
  - Go to RD_ISSUE if read, WR if write.
- RD_ISSUE:
  - Each edge drives ram_read=1 and ram_address=addr+beat (registered), then beat++.
  - One read per cycle, no bubbles.
  - Beat 0 read strobe is visible in the cycle after A.
  - After the last beat is issued, go to RD_DRAIN with ram_read=0.
- Read return:
  - A beat issued at edge E (RAM samples at E+1) has ram_Q valid after edge E+1+READ_LATENCY-1.
  - rdata is registered from ram_Q on the following edge, with rvalid=1 for exactly one cycle.
  - With READ_LATENCY=1, the first rvalid is high in the cycle after edge A+3; subsequent beats follow every cycle.
- RD_DRAIN:
  - Wait until the pending pipeline is empty.
  - done=1 coincides with the last rvalid; then FINISH.
- WR:
  - wdata_ready=1 combinationally whenever state==WR and beats remain.
  - On each edge with wdata_valid&wdata_ready: ram_write=1, ram_D=wdata, ram_address=addr+beat (registered), beat++.
  - If wdata_valid=0, ram_write=0 that cycle and the state holds (stall, no timeout).
  - After the last beat's ram_write cycle, go to FINISH and assert done for one cycle.
- FINISH: one cycle with done=0, busy=1; then IDLE. Back-to-back requests therefore have a one-cycle gap.
- Invariants:
  - ram_read and ram_write are never both 1; the RAM gives write priority, so this is mandatory.
  - ram_read=ram_write=0 in IDLE and FINISH.
- Address arithmetic: modulo 2^ADDR_W. A burst from 510 with len=3 accesses 510, 511, 0, 1.
- req_valid while busy: ignored (req_ready=0); the request must be held by the requester.
- clear mid-burst: in-flight reads are discarded with no rvalid or done; write beats not yet strobed are dropped; the RAM keeps already-written words.
- Request fields are sampled only at acceptance; later changes have no effect.

Decomposition:
- Package `mem_ctrl_pkg`:
  - State encoding (IDLE..FINISH).
  - Constants ADDR_W=9, DATA_W=32, RAM_DEPTH=512, LEN_W=3.
- Sub-module `rd_valid_pipe`: READ_LATENCY+1-deep shift register of read-issued bits; provides the capture strobe and a pending-empty flag to the FSM.

Test Plan:
1. Single read: preload mem[0x010]=0xDEADBEEF; req read addr=0x010 len=0 → one rvalid with rdata=0xDEADBEEF, done in the same cycle, 3 edges after acceptance; ram_read high exactly 1 cycle.
2. Burst read with wrap: mem[510..511,0..1]=1,2,3,4; req addr=510 len=3 → rvalid on 4 consecutive cycles with rdata 1,2,3,4; ram_address sequence 510,511,0,1; done with the 4th beat.
3. Stalled write burst: req write addr=0x020 len=2; wdata 0xA,0xB,0xC with wdata_valid low for 2 cycles between B and C → ram_write pulses only on accepted beats; readback of 0x020..0x022 = A,B,C; one done pulse.
4. Strobe exclusivity: random mixed read/write bursts for 2000 cycles → assertion that ram_read&ram_write never both 1; scoreboard matches a reference memory model.
5. clear mid-read: req read len=7; assert clear on the 3rd issue cycle → no further rvalid or done; all outputs 0 after the clear edge; a new read request after clear returns correct data.
6. Busy handshake: req_valid held during an active burst → req_ready=0 and request not accepted until 1 cycle after done; busy high from acceptance through FINISH.

Source files
------------

// File: rtl/ram_access_controller_pkg.sv
// Shared constants and FSM state encoding for the RAM access controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W       = 9;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned RAM_DEPTH    = 512;
  localparam int unsigned LEN_W        = 3;
  localparam int unsigned READ_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    WR,
    FINISH
  } state_t;

endpackage

// File: rtl/ram_access_controller_if.sv
// CPU-side request / write-beat / read-beat bundle of the RAM access controller.
interface ram_access_controller_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              done;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, wdata_valid,
    input  req_ready, wdata_ready, rdata, rvalid, done, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid,
    output req_ready, wdata_ready, rdata, rvalid, done, busy
  );
endinterface

// File: rtl/ram_access_controller_rd_valid_pipe.sv
// Tracks issued read strobes until their RAM data is ready to be captured.
module rd_valid_pipe #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clock,
  input  logic clear,
  input  logic issue,
  output logic capture,
  output logic pending_empty
);
  localparam int unsigned DEPTH = READ_LATENCY + 1;

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = {pipe_q[DEPTH-2:0], issue};
  end

  always_ff @(posedge clock) begin
    if (clear) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  // pending_empty: nothing is in flight behind the beat at the capture stage
  assign capture       = pipe_q[DEPTH-1];
  assign pending_empty = ~|pipe_q[DEPTH-2:0];

endmodule

// File: rtl/ram_access_controller.sv
// Burst read/write master for the 512x32 synchronous RAM; registered RAM strobes,
// per-beat read data stream and a done pulse per transaction.
module ram_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = mem_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W       = mem_ctrl_pkg::DATA_W,
  parameter int unsigned LEN_W        = mem_ctrl_pkg::LEN_W,
  parameter int unsigned READ_LATENCY = mem_ctrl_pkg::READ_LATENCY
) (
  input  logic                    clock,
  input  logic                    clear,
  ram_access_controller_if.slave  cpu,
  output logic [DATA_W-1:0]       ram_D,
  output logic [ADDR_W-1:0]       ram_address,
  output logic                    ram_read,
  output logic                    ram_write,
  input  logic [DATA_W-1:0]       ram_Q
);
  localparam logic [LEN_W:0] BEAT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [LEN_W:0]    beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;

  logic              capture, pending_empty;
  logic              beats_left, last_beat;
  logic [ADDR_W-1:0] beat_addr;

  rd_valid_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_valid_pipe (
    .clock         (clock),
    .clear         (clear),
    .issue         (ram_read_d),
    .capture       (capture),
    .pending_empty (pending_empty)
  );

  assign beats_left = (beat_q <= {1'b0, len_q});
  assign last_beat  = (beat_q == {1'b0, len_q});
  assign beat_addr  = base_q + ADDR_W'(beat_q);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    len_d       = len_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_d_d     = ram_d_q;
    rdata_d     = capture ? ram_Q : rdata_q;
    rvalid_d    = capture;
    done_d      = 1'b0;

    // done is registered, so the FSM leaves RD_DRAIN/WR one edge after raising it
    unique case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          base_d  = cpu.req_addr;
          len_d   = cpu.req_len;
          beat_d  = '0;
          state_d = cpu.req_write ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        ram_read_d = 1'b1;
        ram_addr_d = beat_addr;
        beat_d     = beat_q + BEAT_ONE;
        if (last_beat) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (done_q)                          state_d = FINISH;
        else if (capture && pending_empty)   done_d  = 1'b1;
      end
      WR: begin
        if (beats_left) begin
          if (cpu.wdata_valid) begin
            ram_write_d = 1'b1;
            ram_d_d     = cpu.wdata;
            ram_addr_d  = beat_addr;
            beat_d      = beat_q + BEAT_ONE;
          end
        end else if (done_q) begin
          state_d = FINISH;
        end else begin
          done_d = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_d_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      len_q       <= len_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_d_q     <= ram_d_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
    end
  end

  assign cpu.req_ready   = (state_q == IDLE) && !clear;
  assign cpu.wdata_ready = (state_q == WR) && beats_left;
  assign cpu.busy        = (state_q != IDLE);
  assign cpu.rdata       = rdata_q;
  assign cpu.rvalid      = rvalid_q;
  assign cpu.done        = done_q;

  assign ram_read    = ram_read_q;
  assign ram_write   = ram_write_q;
  assign ram_address = ram_addr_q;
  assign ram_D       = ram_d_q;

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed table-driven bench for ram_access_controller with a behavioural 512x32 RAM.
module tb_ram_access_controller;
  import mem_ctrl_pkg::*;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  ram_access_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) cpu_if ();

  logic [DATA_W-1:0] ram_D;
  logic [DATA_W-1:0] ram_Q = '0;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_read, ram_write;

  ram_access_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .READ_LATENCY(1)
  ) dut (
    .clock(clock), .clear(clear), .cpu(cpu_if),
    .ram_D(ram_D), .ram_address(ram_address), .ram_read(ram_read),
    .ram_write(ram_write), .ram_Q(ram_Q)
  );

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  logic        bd_we   = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  // RAM: write has priority, registered output, backdoor port for preload
  always @(posedge clock) begin
    if (bd_we)          mem[bd_addr] <= bd_data;
    else if (ram_write) mem[ram_address] <= ram_D;
    else if (ram_read)  ram_Q <= mem[ram_address];
  end

  int n_vec = 0, n_err = 0, excl_viol = 0;
  always @(negedge clock) if (ram_read && ram_write) excl_viol++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic            wr;
    logic [8:0]      addr;
    logic [2:0]      len;
    logic [7:0]      stall;
    logic [7:0][31:0] data;
  } vec_t;

  function automatic vec_t mkv(input logic wr, input logic [8:0] a, input logic [2:0] l,
                               input logic [7:0] s, input logic [31:0] d0, d1, d2, d3,
                               input logic [31:0] d4, d5, d6, d7);
    mkv.wr = wr; mkv.addr = a; mkv.len = l; mkv.stall = s;
    mkv.data = {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic bd_write(input logic [8:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cpu_if.req_ready && k < 50) begin @(negedge clock); k++; end
    chk("req_ready_wait", 32'(cpu_if.req_ready), 32'd1);
  endtask

  // Issue one transaction and check strobes, beats, done and FINISH.
  task automatic run_txn(input logic wr, input logic [8:0] addr, input logic [2:0] len,
                         input logic [7:0][31:0] data, input logic [7:0] stall);
    int nb = int'(len) + 1;
    int nreads = 0, nwrites = 0, beat_in = 0, beat_out = 0, gap = 0;
    bit got_done = 0;
    logic [8:0] ea;
    wait_ready();
    cpu_if.req_valid = 1'b1; cpu_if.req_write = wr;
    cpu_if.req_addr = addr; cpu_if.req_len = len;
    @(negedge clock);
    cpu_if.req_valid = 1'b0; cpu_if.req_write = ~wr;
    cpu_if.req_addr = ~addr; cpu_if.req_len = ~len;
    for (int n = 0; n < 60 && !got_done; n++) begin
      if (n > 0) @(negedge clock);
      if (ram_read) begin
        ea = addr + 9'(nreads);
        if (nreads == 0) chk("rd_first_strobe", 32'(n), 32'd1);
        chk("rd_addr", 32'(ram_address), 32'(ea));
        nreads++;
      end
      if (ram_write) begin
        ea = addr + 9'(nwrites);
        chk("wr_addr", 32'(ram_address), 32'(ea));
        if (nwrites < 8) chk("wr_data", ram_D, data[nwrites]);
        nwrites++;
      end
      if (cpu_if.rvalid) begin
        if (beat_out == 0) chk("rd_latency", 32'(n), 32'd3);
        if (beat_out < 8) chk("rdata", cpu_if.rdata, data[beat_out]);
        beat_out++;
      end
      if (cpu_if.done) begin
        got_done = 1;
        if (!wr) chk("done_with_last_rvalid", 32'(cpu_if.rvalid && beat_out == nb), 32'd1);
      end
      if (wr && beat_in < nb) begin
        if (stall[beat_in] && gap < 2) begin
          cpu_if.wdata_valid = 1'b0; gap++;
        end else begin
          cpu_if.wdata_valid = 1'b1; cpu_if.wdata = data[beat_in];
          if (cpu_if.wdata_ready) begin beat_in++; gap = 0; end
        end
      end else begin
        cpu_if.wdata_valid = 1'b0;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("read_strobes", 32'(nreads), wr ? 32'd0 : 32'(nb));
    chk("write_strobes", 32'(nwrites), wr ? 32'(nb) : 32'd0);
    chk("rvalid_beats", 32'(beat_out), wr ? 32'd0 : 32'(nb));
    if (wr) begin
      for (int i = 0; i < nb; i++) begin
        ea = addr + 9'(i);
        chk("mem_content", mem[ea], data[i]);
        ref_mem[ea] = data[i];
      end
    end
    @(negedge clock);
    chk("finish_cycle", 32'({cpu_if.done, cpu_if.busy, cpu_if.req_ready, cpu_if.rvalid,
                             ram_read, ram_write}), 32'b010000);
  endtask

  vec_t vecs[8];
  logic [7:0][31:0] dv;
  int   nrv, ndn;

  initial begin
    cpu_if.req_valid = 1'b0; cpu_if.req_write = 1'b0; cpu_if.req_addr = '0;
    cpu_if.req_len = '0; cpu_if.wdata = '0; cpu_if.wdata_valid = 1'b0;

    vecs[0] = mkv(0, 9'h010, 3'd0, 8'h00, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkv(0, 9'h1FE, 3'd3, 8'h00, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0);
    vecs[2] = mkv(1, 9'h020, 3'd2, 8'h04, 32'hA, 32'hB, 32'hC, 0, 0, 0, 0, 0);
    vecs[3] = mkv(0, 9'h020, 3'd2, 8'h00, 32'hA, 32'hB, 32'hC, 0, 0, 0, 0, 0);
    vecs[4] = mkv(1, 9'h1FF, 3'd1, 8'h02, 32'h11111111, 32'h22222222, 0, 0, 0, 0, 0, 0);
    vecs[5] = mkv(0, 9'h1FE, 3'd3, 8'h00, 32'd1, 32'h11111111, 32'h22222222, 32'd4,
                  0, 0, 0, 0);
    vecs[6] = mkv(1, 9'h100, 3'd7, 8'h01, 32'h10000000, 32'h20000000, 32'h30000000,
                  32'h40000000, 32'h50000000, 32'h60000000, 32'h70000000, 32'h80000000);
    vecs[7] = mkv(0, 9'h100, 3'd7, 8'h00, 32'h10000000, 32'h20000000, 32'h30000000,
                  32'h40000000, 32'h50000000, 32'h60000000, 32'h70000000, 32'h80000000);

    // Preload under reset
    @(negedge clock);
    for (int i = 0; i < 512; i++) bd_write(9'(i), 32'hC0DE0000 | 32'(i));
    bd_write(9'h010, 32'hDEADBEEF);
    bd_write(9'h1FE, 32'd1); bd_write(9'h1FF, 32'd2);
    bd_write(9'h000, 32'd3); bd_write(9'h001, 32'd4);

    chk("reset_req_ready", 32'(cpu_if.req_ready), 32'd0);
    chk("reset_flags", 32'({ram_read, ram_write, cpu_if.rvalid, cpu_if.done,
                            cpu_if.busy, cpu_if.wdata_ready}), 32'd0);
    chk("reset_ram_address", 32'(ram_address), 32'd0);
    chk("reset_ram_D", ram_D, 32'd0);
    chk("reset_rdata", cpu_if.rdata, 32'd0);
    clear = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", 32'(cpu_if.req_ready), 32'd1);

    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].stall);

    // Request held through a transaction: next acceptance only after FINISH
    wait_ready();
    cpu_if.req_valid = 1'b1; cpu_if.req_write = 1'b0;
    cpu_if.req_addr = 9'h010; cpu_if.req_len = 3'd0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clock);
      chk("held_req_ready", 32'(cpu_if.req_ready), (n == 5) ? 32'd1 : 32'd0);
      chk("held_busy", 32'(cpu_if.busy), (n == 5) ? 32'd0 : 32'd1);
      chk("held_done", 32'(cpu_if.done), (n == 3) ? 32'd1 : 32'd0);
    end
    cpu_if.req_valid = 1'b0;
    for (int k = 0; k < 20 && !cpu_if.done; k++) @(negedge clock);
    chk("held_second_done", 32'(cpu_if.done), 32'd1);
    chk("held_second_rdata", cpu_if.rdata, 32'hDEADBEEF);

    // clear during the third issue cycle of an 8-beat read
    wait_ready();
    cpu_if.req_valid = 1'b1; cpu_if.req_write = 1'b0;
    cpu_if.req_addr = 9'h100; cpu_if.req_len = 3'd7;
    @(negedge clock);
    cpu_if.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_clear_rvalid", 32'(cpu_if.rvalid), 32'd1);
    chk("pre_clear_rdata", cpu_if.rdata, 32'h10000000);
    clear = 1'b1;
    @(negedge clock);
    chk("clear_flags", 32'({ram_read, ram_write, cpu_if.rvalid, cpu_if.done, cpu_if.busy,
                            cpu_if.wdata_ready, cpu_if.req_ready}), 32'd0);
    chk("clear_ram_address", 32'(ram_address), 32'd0);
    chk("clear_ram_D", ram_D, 32'd0);
    chk("clear_rdata", cpu_if.rdata, 32'd0);
    clear = 1'b0;
    nrv = 0; ndn = 0;
    repeat (20) begin
      @(negedge clock);
      if (cpu_if.rvalid || ram_read) nrv++;
      if (cpu_if.done) ndn++;
    end
    chk("post_clear_rvalid", 32'(nrv), 32'd0);
    chk("post_clear_done", 32'(ndn), 32'd0);
    run_txn(1'b0, 9'h020, 3'd2, vecs[3].data, 8'h00);

    // Mixed random bursts against the reference memory
    for (int t = 0; t < 120; t++) begin
      logic       rw;
      logic [8:0] ra;
      logic [2:0] rl;
      rw = 1'($urandom_range(0, 1));
      ra = 9'($urandom_range(0, 511));
      rl = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) dv[i] = rw ? $urandom : ref_mem[9'(ra + 9'(i))];
      run_txn(rw, ra, rl, dv, 8'($urandom));
    end

    chk("strobe_exclusive", 32'(excl_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
